// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // Which requester a returning read belongs to.
  typedef enum logic {
    OWN_P = 1'b0,
    OWN_A = 1'b1
  } owner_t;

  // Arbiter state. These are plain constants so that older tools can read
  // and compare the encoding directly.
  typedef logic [0:0] state_t;
  localparam state_t PPRI  = 1'b0;
  localparam state_t ALOCK = 1'b1;

  // Return tag that travels alongside each granted access.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rtag_t;

  localparam rtag_t RTAG_NONE = '{valid: 1'b0, owner: OWN_P};

  // The starvation counter has to hold 0..max_wait. It is never narrower
  // than one bit, even when max_wait is 0.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_rtag_pipe.sv
// Return-tag delay line. It matches the dmem read latency, so the tag at the
// tail lines up with the mem_q word it describes.
module dmem_arb_rtag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clock,
  input  logic  reset,
  input  rtag_t push,
  output rtag_t tail
);

  rtag_t stage [0:DEPTH-1];

  // Shift every cycle. A reset drops every in-flight tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RTAG_NONE;
      end
    end else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port dmem syncram.
// The processor (P) has priority. The aux/loader port (A) gets a guaranteed
// slot after MAX_WAIT denied cycles, and it can hold the memory with a
// locked burst. Read data is steered back to whichever port issued the read.
// Optional build macro DMEM_ARB_STATS_EN adds saturating grant/stall counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              a_req,
  input  logic              a_wren,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_a_grants,
  output logic [15:0]       stat_p_stalls
`endif
);

  // state  | meaning
  // PPRI   | processor wins ties; aux is forced in after MAX_WAIT denials
  // ALOCK  | aux holds a locked burst and wins ties

  localparam int              CNT_W    = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
  localparam logic            OVR_EN   = (MAX_WAIT != 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             override;
  logic             p_win;
  logic             a_win;
  rtag_t            push;
  rtag_t            tail;
  logic [DATA_W-1:0] p_hold;
  logic [DATA_W-1:0] a_hold;

  // Pick at most one winner from the requests and the registered state.
  always_comb begin
    override = a_req && OVR_EN && (wait_cnt == WAIT_MAX);
    p_win    = 1'b0;
    a_win    = 1'b0;
    if (state == ALOCK) begin
      if (a_req) begin
        a_win = 1'b1;
      end else if (p_req) begin
        p_win = 1'b1;
      end
    end else if (override) begin
      a_win = 1'b1;
    end else if (p_req) begin
      p_win = 1'b1;
    end else if (a_req) begin
      a_win = 1'b1;
    end
  end

  // Reset forces both grants low, so nothing reaches the memory while reset
  // is asserted.
  assign p_gnt = p_win && !reset;
  assign a_gnt = a_win && !reset;

  // Lock entry and exit. The access that ends a lock is still granted.
  always_comb begin
    state_nxt = state;
    case (state)
      PPRI: begin
        if (a_gnt && a_lock) begin
          state_nxt = ALOCK;
        end
      end
      ALOCK: begin
        if (!a_req || (a_gnt && !a_lock)) begin
          state_nxt = PPRI;
        end
      end
      default: state_nxt = PPRI;
    endcase
  end

  // Count consecutive denied aux cycles in PPRI, saturating at MAX_WAIT.
  always_comb begin
    wait_nxt = '0;
    if ((state == PPRI) && a_req && !a_gnt) begin
      if (wait_cnt == WAIT_MAX) begin
        wait_nxt = wait_cnt;
      end else begin
        wait_nxt = wait_cnt + CNT_W'(1);
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PPRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Drive dmem from the granted port. When idle, the P-side address and data
  // pass through, but writes stay disabled.
  always_comb begin
    mem_address = p_addr;
    mem_data    = p_wdata;
    mem_wren    = 1'b0;
    if (reset) begin
      mem_address = '0;
      mem_data    = '0;
    end else if (a_gnt) begin
      mem_address = a_addr;
      mem_data    = a_wdata;
      mem_wren    = a_wren;
    end else if (p_gnt) begin
      mem_wren    = p_wren;
    end
  end

  // Tag each granted access. Writes push an invalid tag, so the pipe keeps
  // its one-tag-per-grant spacing.
  always_comb begin
    push = RTAG_NONE;
    if (a_gnt) begin
      push.valid = !a_wren;
      push.owner = OWN_A;
    end else if (p_gnt) begin
      push.valid = !p_wren;
      push.owner = OWN_P;
    end
  end

  dmem_arb_rtag_pipe #(
    .DEPTH (READ_LAT)
  ) u_rtag_pipe (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .tail  (tail)
  );

  assign p_rvalid = tail.valid && (tail.owner == OWN_P) && !reset;
  assign a_rvalid = tail.valid && (tail.owner == OWN_A) && !reset;

  // mem_q passes straight through on the return cycle. Otherwise each port
  // keeps showing the last word it received.
  assign p_rdata = p_rvalid ? mem_q : p_hold;
  assign a_rdata = a_rvalid ? mem_q : a_hold;

  // Remember the last returned word per port.
  always_ff @(posedge clock) begin
    if (reset) begin
      p_hold <= '0;
      a_hold <= '0;
    end else begin
      if (p_rvalid) begin
        p_hold <= mem_q;
      end
      if (a_rvalid) begin
        a_hold <= mem_q;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating aux-grant and processor-stall counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_a_grants <= '0;
      stat_p_stalls <= '0;
    end else begin
      if (a_gnt && (stat_a_grants != 16'hFFFF)) begin
        stat_a_grants <= stat_a_grants + 16'd1;
      end
      if (p_req && !p_gnt && (stat_p_stalls != 16'hFFFF)) begin
        stat_p_stalls <= stat_p_stalls + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all scored against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int RL   = 1;
  localparam int MAXW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          p_req, p_wren, p_gnt, p_rvalid;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          a_req, a_wren, a_lock, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_wren;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_a_grants, stat_p_stalls;
`endif

  dmem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (RL),
    .MAX_WAIT (MAXW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .p_req       (p_req),
    .p_wren      (p_wren),
    .p_addr      (p_addr),
    .p_wdata     (p_wdata),
    .p_gnt       (p_gnt),
    .p_rvalid    (p_rvalid),
    .p_rdata     (p_rdata),
    .a_req       (a_req),
    .a_wren      (a_wren),
    .a_lock      (a_lock),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_a_grants (stat_a_grants),
    .stat_p_stalls (stat_p_stalls)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural syncram with RL cycles of read latency.
  logic [DW-1:0] dmem    [0:4095];
  logic [DW-1:0] q_pipe  [0:RL-1];
  always @(posedge clock) begin
    if (mem_wren) dmem[mem_address] <= mem_data;
    q_pipe[0] <= dmem[mem_address];
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RL-1];

  // Reference model state.
  typedef struct {
    int            due;
    bit            own_a;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] ref_mem [0:4095];
  ret_t          retq[$];
  int            starve;
  bit            locked;
  int            cyc;
  logic [DW-1:0] last_p, last_a;
  bit            eg_p, eg_a;
  int            n_agnt, n_pstall;
  int            checks, failures;

  // DUT outputs as seen in the most recent cycle, used by the directed checks.
  logic          s_p_gnt, s_a_gnt, s_p_rvalid, s_a_rvalid, s_mem_wren;
  logic [DW-1:0] s_p_rdata, s_a_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  // Runs one clock cycle: score the DUT against the model, then advance both.
  task automatic tick();
    bit            xp, xa, rv_p, rv_a;
    logic [DW-1:0] rd;
    #3;
    xp = 1'b0;
    xa = 1'b0;
    if (!reset) begin
      if (locked) begin
        if (a_req) xa = 1'b1;
        else if (p_req) xp = 1'b1;
      end else if (a_req && (MAXW != 0) && (starve >= MAXW)) begin
        xa = 1'b1;
      end else if (p_req) begin
        xp = 1'b1;
      end else if (a_req) begin
        xa = 1'b1;
      end
    end
    rv_p = 1'b0;
    rv_a = 1'b0;
    rd   = '0;
    if (!reset && (retq.size() > 0) && (retq[0].due == cyc)) begin
      rv_p = !retq[0].own_a;
      rv_a = retq[0].own_a;
      rd   = retq[0].data;
      void'(retq.pop_front());
    end

    s_p_gnt = p_gnt;       s_a_gnt = a_gnt;
    s_p_rvalid = p_rvalid; s_a_rvalid = a_rvalid;
    s_p_rdata = p_rdata;   s_a_rdata = a_rdata;
    s_mem_wren = mem_wren;

    chk("p_gnt", 32'(p_gnt), 32'(xp));
    chk("a_gnt", 32'(a_gnt), 32'(xa));
    chk("mem_wren", 32'(mem_wren), 32'((xa && a_wren) || (xp && p_wren)));
    if (reset) begin
      chk("rst_mem_address", 32'(mem_address), 32'd0);
      chk("rst_mem_data", mem_data, 32'd0);
    end else if (xa) begin
      chk("a_mem_address", 32'(mem_address), 32'(a_addr));
      if (a_wren) chk("a_mem_data", mem_data, a_wdata);
    end else begin
      chk("p_mem_address", 32'(mem_address), 32'(p_addr));
      if (xp && p_wren) chk("p_mem_data", mem_data, p_wdata);
    end
    chk("p_rvalid", 32'(p_rvalid), 32'(rv_p));
    chk("a_rvalid", 32'(a_rvalid), 32'(rv_a));
    if (!reset) begin
      chk("p_rdata", p_rdata, rv_p ? rd : last_p);
      chk("a_rdata", a_rdata, rv_a ? rd : last_a);
    end

    if (reset) begin
      starve = 0;
      locked = 1'b0;
      retq.delete();
      last_p = '0;
      last_a = '0;
      n_agnt = 0;
      n_pstall = 0;
    end else begin
      if (rv_p) last_p = rd;
      if (rv_a) last_a = rd;
      if (xa) begin
        if (a_wren) ref_mem[a_addr] = a_wdata;
        else retq.push_back('{cyc + RL, 1'b1, ref_mem[a_addr]});
        n_agnt++;
      end
      if (xp) begin
        if (p_wren) ref_mem[p_addr] = p_wdata;
        else retq.push_back('{cyc + RL, 1'b0, ref_mem[p_addr]});
      end
      if (p_req && !xp) n_pstall++;
      if (locked) begin
        starve = 0;
        if (!a_req || (xa && !a_lock)) locked = 1'b0;
      end else begin
        if (xa && a_lock) locked = 1'b1;
        if (a_req && !xa) starve = (starve < MAXW) ? starve + 1 : starve;
        else starve = 0;
      end
    end
    eg_p = xp;
    eg_a = xa;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    checks = 0; failures = 0; cyc = 0;
    starve = 0; locked = 1'b0; last_p = '0; last_a = '0;
    eg_p = 1'b0; eg_a = 1'b0; n_agnt = 0; n_pstall = 0;
    for (int i = 0; i < 4096; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[12'h020] = 32'hDEADBEEF; ref_mem[12'h020] = 32'hDEADBEEF;
    dmem[12'h021] = 32'h12345678; ref_mem[12'h021] = 32'h12345678;

    reset = 1'b1;
    p_req = 0; p_wren = 0; p_addr = 12'h7A5; p_wdata = 32'h0;
    a_req = 0; a_wren = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    @(posedge clock);
    #1;
    tick();
    tick();
    reset = 1'b0;
    p_addr = '0;
    tick();
    chk("reset_p_rdata", s_p_rdata, 32'd0);
    chk("reset_state", 32'(dut.state), 32'd0);

    // Processor priority, then the forced aux slot on the fifth denied cycle.
    p_req = 1; p_wren = 0;
    a_req = 1; a_wren = 1; a_lock = 0; a_addr = 12'h010; a_wdata = 32'hA5A5_0010;
    for (int i = 0; i < 3; i++) begin
      p_addr = 12'h030 + AW'(i);
      tick();
      chk("prio_p_gnt", 32'(s_p_gnt), 32'd1);
    end
    chk("prio_wait_cnt", 32'(dut.wait_cnt), 32'd3);
    p_addr = 12'h033;
    tick();
    chk("starve_4_a_gnt", 32'(s_a_gnt), 32'd0);
    tick();
    chk("starve_5_a_gnt", 32'(s_a_gnt), 32'd1);
    chk("starve_5_p_gnt", 32'(s_p_gnt), 32'd0);
    chk("starve_wait_clr", 32'(dut.wait_cnt), 32'd0);
    a_req = 0;
    tick();
    p_req = 0;
    tick();

    // Interleaved reads are routed back to their owners.
    p_req = 1; p_wren = 0; p_addr = 12'h020;
    tick();
    p_req = 0;
    a_req = 1; a_wren = 0; a_addr = 12'h021;
    tick();
    chk("route_p_rvalid", 32'(s_p_rvalid), 32'd1);
    chk("route_p_rdata", s_p_rdata, 32'hDEADBEEF);
    a_req = 0;
    tick();
    chk("route_a_rvalid", 32'(s_a_rvalid), 32'd1);
    chk("route_a_rdata", s_a_rdata, 32'h12345678);
    chk("route_p_hold", s_p_rdata, 32'hDEADBEEF);

    // Locked aux burst shuts out the processor until the lock drops.
    a_req = 1; a_wren = 1; a_lock = 1; a_addr = 12'h100; a_wdata = 32'h1111_0100;
    tick();
    chk("lock_first_a_gnt", 32'(s_a_gnt), 32'd1);
    p_req = 1; p_wren = 0; p_addr = 12'h050;
    for (int k = 1; k < 4; k++) begin
      a_addr = 12'h100 + AW'(k);
      a_wdata = 32'h1111_0100 + k;
      tick();
      chk("lock_a_gnt", 32'(s_a_gnt), 32'd1);
      chk("lock_p_gnt", 32'(s_p_gnt), 32'd0);
    end
    a_req = 0; a_lock = 0;
    tick();
    chk("unlock_p_gnt", 32'(s_p_gnt), 32'd1);
    chk("unlock_state", 32'(dut.state), 32'd0);
    p_req = 0;
    tick();

    // Aux write, then a processor read of the same word.
    a_req = 1; a_wren = 1; a_addr = 12'h3FF; a_wdata = 32'hCAFE0001;
    tick();
    chk("wr_mem_wren", 32'(s_mem_wren), 32'd1);
    a_req = 0;
    tick();
    chk("wr_no_rvalid", 32'(s_a_rvalid | s_p_rvalid), 32'd0);
    chk("wr_one_cycle", 32'(s_mem_wren), 32'd0);
    p_req = 1; p_wren = 0; p_addr = 12'h3FF;
    tick();
    p_req = 0;
    tick();
    chk("wr_readback_rvalid", 32'(s_p_rvalid), 32'd1);
    chk("wr_readback_rdata", s_p_rdata, 32'hCAFE0001);

    // Reset the cycle after a granted read; the return must never appear.
    p_req = 1; p_addr = 12'h020;
    tick();
    p_req = 0;
    reset = 1;
    tick();
    chk("rst_mid_p_rvalid", 32'(s_p_rvalid), 32'd0);
    reset = 0; p_addr = '0;
    tick();
    chk("rst_after_p_rvalid", 32'(s_p_rvalid), 32'd0);
    chk("rst_after_p_rdata", s_p_rdata, 32'd0);
    chk("rst_after_state", 32'(dut.state), 32'd0);

    // Randomized traffic. Each requester holds its request until granted.
    for (int i = 0; i < 4000; i++) begin
      if (!p_req || eg_p) begin
        p_req   = ($urandom_range(0, 3) != 0);
        p_wren  = $urandom_range(0, 1);
        p_addr  = rand_addr();
        p_wdata = $urandom;
      end
      if (!a_req || eg_a) begin
        a_req   = ($urandom_range(0, 2) == 0) || (locked && ($urandom_range(0, 3) != 0));
        a_wren  = $urandom_range(0, 1);
        a_lock  = ($urandom_range(0, 4) == 0) || (locked && ($urandom_range(0, 2) != 0));
        a_addr  = rand_addr();
        a_wdata = $urandom;
      end
      reset = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 0;

`ifdef DMEM_ARB_STATS_EN
    chk("stat_a_grants", 32'(stat_a_grants), 32'(n_agnt));
    chk("stat_p_stalls", 32'(stat_p_stalls), 32'(n_pstall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem syncram between two requesters: the processor (port P) and an auxiliary loader/debug master (port A).
- Arbitrates once per cycle. Routes the granted request to dmem, then steers the synchronous read data back to the requester that issued the read.
- Sits between processor/aux and dmem. Uses the same 12-bit address and 32-bit data as dmem.

Parameters:
- ADDR_W, 12, dmem address width
- DATA_W, 32, dmem data width
- READ_LAT, 1, cycles from granted read to valid mem_q (1..3)
- MAX_WAIT, 8, consecutive aux-denied cycles before aux is forced a slot; 0 = strict processor priority

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- p_req  in  1  processor access request
- p_wren  in  1  processor write enable (0 = read)
- p_addr  in  ADDR_W  processor address
- p_wdata  in  DATA_W  processor write data
- p_gnt  out  1  processor request accepted this cycle
- p_rvalid  out  1  processor read data valid
- p_rdata  out  DATA_W  processor read data
- a_req  in  1  aux request
- a_wren  in  1  aux write enable
- a_lock  in  1  aux requests a locked burst
- a_addr  in  ADDR_W  aux address
- a_wdata  in  DATA_W  aux write data
- a_gnt  out  1  aux request accepted
- a_rvalid  out  1  aux read data valid
- a_rdata  out  DATA_W  aux read data
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem wren
- mem_q  in  DATA_W  from dmem q

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, named `reset`.
- Reset values:
  - state=PPRI, wait_cnt=0, return-tag pipe cleared.
  - All gnt/rvalid outputs 0, rdata 0.
  - mem_wren 0, mem_address 0, mem_data 0.
- Handshake:
  - A requester holds req/addr/wdata/wren stable until gnt.
  - gnt is combinational from req plus registered state.
  - An access completes in the cycle gnt=1.
  - At most one gnt per cycle.
- Memory drive:
  - mem_* is a combinational mux of the granted port.
  - With no grant: mem_wren=0, address and data hold the P-port values. No write can occur.
- FSM states:
  - PPRI (processor priority):
    - p_req wins, unless the override is active; override = a_req && MAX_WAIT!=0 && wait_cnt==MAX_WAIT.
    - Override cycle: a_gnt=1 and p_gnt=0. The processor stalls one cycle.
    - Transition to ALOCK when a_gnt && a_lock.
  - ALOCK:
    - a_req wins over p_req.
    - Return to PPRI on the first cycle with a_req=0, or on a_gnt with a_lock=0; that access is still granted.
- wait_cnt:
  - Increments when a_req && !a_gnt, saturating at MAX_WAIT.
  - Clears on a_gnt or !a_req.
  - Held at 0 in ALOCK.
- Read return:
  - Each granted read (wren=0) pushes tag {valid, owner} into a READ_LAT-deep shift register. Writes push an invalid tag.
  - At the tail: owner's rvalid=1 for exactly one cycle, and owner's rdata=mem_q.
  - The other port's rvalid=0. rdata holds its last value.
- Back-to-back reads: the ports may interleave every cycle. Returns arrive in grant order, one per cycle.
- Reset mid-operation: in-flight tags are discarded and no rvalid fires for them. A lock is abandoned (state=PPRI).
- Widths: no arithmetic on data. The counter width is $clog2(MAX_WAIT+1), minimum 1.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_a_grants[15:0] and stat_p_stalls[15:0], both zeroed by reset and saturating.
  - stat_a_grants counts a_gnt cycles.
  - stat_p_stalls counts cycles with p_req && !p_gnt.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - owner typedef (OWN_P, OWN_A)
  - state typedef (PPRI, ALOCK)
  - rtag struct {valid, owner}
- One sub-module, dmem_arb_rtag_pipe: the parameterised READ_LAT-deep tag shift register with synchronous clear.

Test Plan:
- Priority: p_req=1 and a_req=1 for 3 cycles, MAX_WAIT=8 -> p_gnt=1 each cycle, a_gnt=0, wait_cnt=3.
- Starvation: p_req held 1, a_req=1, addr 0x010, MAX_WAIT=4 -> a_gnt=1 in the 5th cycle only, p_gnt=0 that cycle, then wait_cnt=0.
- Read routing:
  - Preload dmem[0x020]=0xDEADBEEF and dmem[0x021]=0x12345678.
  - P reads 0x020 at cycle n, A reads 0x021 at n+1 (READ_LAT=1).
  - Expect p_rvalid at n+1 with 0xDEADBEEF, and a_rvalid at n+2 with 0x12345678.
- Lock: A grants with a_lock=1 for 4 writes to 0x100..0x103 while p_req=1 -> 4 a_gnt, no p_gnt; then a_lock=0 -> PPRI, p_gnt next cycle.
- Write: A writes 0xCAFE0001 to 0x3FF -> mem_wren=1 for one cycle, no rvalid; a later P read of 0x3FF returns 0xCAFE0001.
- Reset mid-read: assert reset the cycle after a granted P read -> p_rvalid stays 0, state=PPRI, and all outputs are at reset values.
